// File: rtl/seq_pkg.sv
// Shared definitions for the register micro-sequencer: instruction fields,
// opcodes and controller states.
package seq_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 14;
    localparam int DST_HI = 13;
    localparam int DST_LO = 12;
    localparam int SRC_HI = 11;
    localparam int SRC_LO = 10;
    localparam int RSV_HI = 9;
    localparam int RSV_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ADD   = 2'b01,
        OP_ADDI  = 2'b10,
        OP_HALT  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_reg_sequencer_if.sv
// Control, program-load and result bundle of the register micro-sequencer.
interface seq_reg_sequencer_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    import seq_pkg::*;

    logic                start;
    logic                prog_we;
    logic [AW-1:0]       prog_addr;
    logic [INSTR_W-1:0]  prog_data;
    logic [DW-1:0]       a;
    logic [DW-1:0]       b;
    logic [DW-1:0]       c;
    logic [DW-1:0]       d;
    logic [AW-1:0]       pc;
    logic                busy;
    logic                done;

    modport master (
        output start, prog_we, prog_addr, prog_data,
        input  a, b, c, d, pc, busy, done
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data,
        output a, b, c, d, pc, busy, done
    );

endinterface

// File: rtl/seq_prog_mem.sv
// Program store: register array with synchronous write, combinational read
// and every entry reset to HALT.
module seq_prog_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= HALT_WORD;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/seq_reg_sequencer.sv
// Micro-sequencer: runs a small loaded program one instruction per cycle,
// sharing one adder/write port across the four result registers.
module seq_reg_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_reg_sequencer_if.slave  bus
);

    state_t             state;
    logic [AW-1:0]      pc_q;
    logic               busy_q;
    logic               done_q;
    logic [DW-1:0]      regs [4];

    logic [INSTR_W-1:0] instr;
    op_t                op;
    logic [1:0]         dst;
    logic [1:0]         src;
    logic [DW-1:0]      imm;
    logic [DW-1:0]      dst_val;
    logic [DW-1:0]      src_val;
    logic [DW-1:0]      add_a;
    logic [DW-1:0]      add_b;
    logic [DW-1:0]      result;
    logic               mem_we;
    logic               unused_rsvd;

    // The store only accepts writes while no program is executing.
    assign mem_we = bus.prog_we && (state != ST_RUN);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    assign op          = op_t'(instr[OP_HI:OP_LO]);
    assign dst         = instr[DST_HI:DST_LO];
    assign src         = instr[SRC_HI:SRC_LO];
    assign imm         = DW'(instr[IMM_HI:IMM_LO]);
    assign unused_rsvd = ^instr[RSV_HI:RSV_LO];
    assign dst_val     = regs[dst];
    assign src_val     = regs[src];

    // ADD sums dst+src, ADDI sums src+imm; both go through the same adder.
    always_comb begin
        add_a = src_val;
        add_b = imm;
        if (op == OP_ADD) begin
            add_a = dst_val;
            add_b = src_val;
        end
        result = (op == OP_LOADI) ? imm : add_a + add_b;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            pc_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        pc_q   <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (op == OP_HALT) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        regs[dst] <= result;
                        // The last entry finishes the run; pc is held, never wrapped.
                        if (pc_q == AW'(DEPTH - 1)) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a    = regs[0];
    assign bus.b    = regs[1];
    assign bus.c    = regs[2];
    assign bus.d    = regs[3];
    assign bus.pc   = pc_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_seq_reg_sequencer.sv
// Bench for seq_reg_sequencer: directed program scenarios plus random
// stimulus, all checked every cycle against a behavioural model.
module tb_seq_reg_sequencer;

    localparam int DEPTH = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    bit   checkEn = 1'b0;
    int   busyTotal = 0;

    int          mRegs [4];
    int          mPc;
    int          mMode;
    logic [15:0] mProg [DEPTH];

    seq_reg_sequencer_if #(.AW(3), .DW(8)) bus ();

    seq_reg_sequencer #(.DEPTH(DEPTH), .AW(3), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int dst, input int src, input int imm);
        return {op[1:0], dst[1:0], src[1:0], 2'b00, imm[7:0]};
    endfunction

    // Reference: what one clock edge does to the architectural state.
    task automatic modelStep(input bit s, input bit we, input logic [2:0] addr,
                             input logic [15:0] data, input bit rstn);
        logic [15:0] w;
        int op, dst, src, imm, v;
        if (!rstn) begin
            for (int i = 0; i < 4; i++) mRegs[i] = 0;
            for (int i = 0; i < DEPTH; i++) mProg[i] = 16'hFFFF;
            mPc = 0;
            mMode = M_IDLE;
            return;
        end
        if (mMode != M_RUN) begin
            if (we) mProg[addr] = data;
            if (s) begin
                mMode = M_RUN;
                mPc = 0;
            end
        end else begin
            w   = mProg[mPc];
            op  = int'(w[15:14]);
            dst = int'(w[13:12]);
            src = int'(w[11:10]);
            imm = int'(w[7:0]);
            if (op == 3) begin
                mMode = M_DONE;
            end else begin
                if (op == 0)      v = imm;
                else if (op == 1) v = (mRegs[dst] + mRegs[src]) % 256;
                else              v = (mRegs[src] + imm) % 256;
                mRegs[dst] = v;
                if (mPc == DEPTH - 1) mMode = M_DONE;
                else mPc = mPc + 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit s, input bit we, input logic [2:0] addr,
                                 input logic [15:0] data, input bit rstn);
        bus.start     = s;
        bus.prog_we   = we;
        bus.prog_addr = addr;
        bus.prog_data = data;
        rst           = rstn;
        @(posedge clk);
        modelStep(s, we, addr, data, rstn);
        #1;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        rst         = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'd0, 16'h0000, 1);
    endtask

    task automatic writeProg(input int addr, input logic [15:0] data);
        applyStimulus(0, 1, addr[2:0], data, 1);
    endtask

    task automatic pulseStart();
        applyStimulus(1, 0, 3'd0, 16'h0000, 1);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 3'd0, 16'h0000, 0);
        applyStimulus(0, 0, 3'd0, 16'h0000, 0);
    endtask

    task automatic loadBasic();
        writeProg(0, enc(0, 0, 0, 2));
        writeProg(1, enc(2, 1, 0, 2));
        writeProg(2, enc(2, 3, 1, 8));
        writeProg(3, 16'hFFFF);
    endtask

    function automatic logic [15:0] randInstr();
        int sel;
        logic [1:0] op;
        logic [15:0] r;
        sel = int'($urandom % 8);
        if (sel < 2)      op = 2'b00;
        else if (sel < 4) op = 2'b01;
        else if (sel < 7) op = 2'b10;
        else              op = 2'b11;
        r = 16'($urandom);
        r[15:14] = op;
        return r;
    endfunction

    // Every-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("a", int'(bus.a), mRegs[0]);
            checkOutput("b", int'(bus.b), mRegs[1]);
            checkOutput("c", int'(bus.c), mRegs[2]);
            checkOutput("d", int'(bus.d), mRegs[3]);
            checkOutput("pc", int'(bus.pc), mPc);
            checkOutput("busy", int'(bus.busy), int'(mMode == M_RUN));
            checkOutput("done", int'(bus.done), int'(mMode == M_DONE));
        end
        if (bus.busy === 1'b1) busyTotal++;
    end

    initial begin
        int b0;
        bus.start     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = 3'd0;
        bus.prog_data = 16'h0000;
        rst           = 1'b0;

        doReset();
        checkEn = 1'b1;
        checkOutput("rst_a", int'(bus.a), 0);
        checkOutput("rst_pc", int'(bus.pc), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);

        // Basic program
        loadBasic();
        b0 = busyTotal;
        pulseStart();
        idle(3);
        checkOutput("basic_done_e3", int'(bus.done), 0);
        checkOutput("basic_a", int'(bus.a), 2);
        checkOutput("basic_b", int'(bus.b), 4);
        checkOutput("basic_c", int'(bus.c), 0);
        checkOutput("basic_d", int'(bus.d), 12);
        idle(1);
        checkOutput("basic_done_e4", int'(bus.done), 1);
        checkOutput("basic_busy_cycles", busyTotal - b0, 4);
        checkOutput("model_basic_d", mRegs[3], 12);

        // Wrap-around, loaded from DONE
        writeProg(0, enc(0, 2, 0, 250));
        writeProg(1, enc(2, 2, 2, 10));
        writeProg(2, 16'hFFFF);
        pulseStart();
        idle(4);
        checkOutput("wrap_c", int'(bus.c), 4);
        checkOutput("wrap_a", int'(bus.a), 2);
        checkOutput("wrap_d", int'(bus.d), 12);
        checkOutput("model_wrap_c", mRegs[2], 4);

        // ADD with dst==src doubles
        writeProg(0, enc(0, 1, 0, 3));
        writeProg(1, enc(1, 1, 1, 0));
        writeProg(2, 16'hFFFF);
        pulseStart();
        idle(4);
        checkOutput("double_b", int'(bus.b), 6);

        // No HALT: run off the end of the store
        doReset();
        for (int i = 0; i < DEPTH; i++) writeProg(i, enc(2, 0, 0, 1));
        b0 = busyTotal;
        pulseStart();
        idle(9);
        checkOutput("nohalt_a", int'(bus.a), 8);
        checkOutput("nohalt_pc", int'(bus.pc), 7);
        checkOutput("nohalt_done", int'(bus.done), 1);
        checkOutput("nohalt_busy_cycles", busyTotal - b0, 8);
        checkOutput("model_nohalt_pc", mPc, 7);

        // Restart from DONE
        doReset();
        loadBasic();
        pulseStart();
        idle(5);
        pulseStart();
        checkOutput("restart_done_drop", int'(bus.done), 0);
        checkOutput("restart_busy", int'(bus.busy), 1);
        idle(5);
        checkOutput("restart_a", int'(bus.a), 2);
        checkOutput("restart_b", int'(bus.b), 4);
        checkOutput("restart_d", int'(bus.d), 12);
        checkOutput("restart_done", int'(bus.done), 1);

        // Reset mid-run, then restart without reprogramming
        pulseStart();
        idle(1);
        applyStimulus(0, 0, 3'd0, 16'h0000, 0);
        checkOutput("midrst_a", int'(bus.a), 0);
        checkOutput("midrst_d", int'(bus.d), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_done", int'(bus.done), 0);
        pulseStart();
        idle(1);
        checkOutput("midrst_halt_done", int'(bus.done), 1);
        checkOutput("midrst_halt_a", int'(bus.a), 0);

        // Write and start on the same IDLE edge
        doReset();
        applyStimulus(1, 1, 3'd0, enc(0, 3, 0, 77), 1);
        idle(3);
        checkOutput("samedge_d", int'(bus.d), 77);
        checkOutput("samedge_done", int'(bus.done), 1);

        // start and prog_we during RUN are ignored
        doReset();
        loadBasic();
        pulseStart();
        applyStimulus(1, 1, 3'd0, enc(0, 0, 0, 99), 1);
        idle(5);
        checkOutput("illegal_a", int'(bus.a), 2);
        checkOutput("illegal_d", int'(bus.d), 12);
        pulseStart();
        idle(5);
        checkOutput("illegal_reread_a", int'(bus.a), 2);
        checkOutput("illegal_reread_done", int'(bus.done), 1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            bit rn, s, we;
            logic [2:0] addr;
            rn   = ($urandom % 64) != 0;
            s    = ($urandom % 6) == 0;
            we   = ($urandom % 3) == 0;
            addr = 3'($urandom % 8);
            applyStimulus(s, we, addr, randInstr(), rn);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
